// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multicycle datapath (fetch/decode/exec/
//            mem/writeback sequencing, PC control, ready-handshake stalls).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int         STATE_W  = 4,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCwrite,
    output logic               PCwriteCondi,
    output logic [1:0]         PCsrc,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXEC    = STATE_W'(6),
        S_ALUWB   = STATE_W'(7),
        S_BRANCH  = STATE_W'(8),
        S_JUMP    = STATE_W'(9),
        S_ADDI_EX = STATE_W'(10),
        S_ADDI_WB = STATE_W'(11)
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   illegal_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        illegal_d    = illegal_q;
        PCwrite      = 1'b0;
        PCwriteCondi = 1'b0;
        PCsrc        = 2'b00;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // PC and IR only advance once the instruction word is valid
                IRWrite = mem_ready;
                PCwrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDI_EX;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b01;
                PCwriteCondi = 1'b1;
                PCsrc        = 2'b01;
            end
            S_JUMP: begin
                PCwrite = 1'b1;
                PCsrc   = 2'b10;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            // Unused encodings fall back to FETCH with every output idle
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign illegal_op = illegal_q;
    assign state_out  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking scoreboard bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    localparam logic [5:0] C_RTYPE = 6'b000000;
    localparam logic [5:0] C_LW    = 6'b100011;
    localparam logic [5:0] C_SW    = 6'b101011;
    localparam logic [5:0] C_BEQ   = 6'b000100;
    localparam logic [5:0] C_J     = 6'b000010;
    localparam logic [5:0] C_ADDI  = 6'b001000;
    localparam logic [5:0] C_BAD   = 6'b111111;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCwrite, PCwriteCondi, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] PCsrc, ALUSrcB, ALUOp;
    logic [3:0] state_out;

    multicycle_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .PCwrite      (PCwrite),
        .PCwriteCondi (PCwriteCondi),
        .PCsrc        (PCsrc),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .illegal_op   (illegal_op),
        .state_out    (state_out)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] outs;
    } rec_t;

    rec_t       sb[$];
    rec_t       r_rec;
    int         total;
    int         bad;
    logic       exp_ill;
    logic [16:0] w_outs;

    // {PCwrite,PCwriteCondi,PCsrc,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,illegal_op}
    assign w_outs = {PCwrite, PCwriteCondi, PCsrc, IorD, MemRead, MemWrite, IRWrite,
                     RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected output vector for a state, straight from the state table
    function automatic logic [16:0] exp_outs(input int st, input logic rd, input logic ill);
        logic pcw, pcc, iord, mr, mw, irw, rdst, m2r, rw, asa;
        logic [1:0] pcs, asb, aop;
        {pcw, pcc, iord, mr, mw, irw, rdst, m2r, rw, asa} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mr = 1'b1; asb = 2'b01; pcw = rd; irw = rd; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mr = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rdst = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; end
            9:  begin pcw = 1'b1; pcs = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcc, pcs, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, ill};
    endfunction

    // One clock cycle: drive inputs, record what this cycle must look like
    task automatic cyc(input logic [5:0] op, input logic rd, input int st);
        opcode    = op;
        mem_ready = rd;
        sb.push_back('{st: 4'(st), outs: exp_outs(st, rd, exp_ill)});
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            r_rec = sb.pop_front();
            chk("state", 32'(state_out), 32'(r_rec.st));
            chk("outs", 32'(w_outs), 32'(r_rec.outs));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        exp_ill   = 1'b0;
        rst       = 1'b0;
        opcode    = C_RTYPE;
        mem_ready = 1'b0;
        #2;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_outs", 32'(w_outs), 32'(exp_outs(0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // LW, no stalls: 0,1,2,3,4
        cyc(C_LW, 1'b1, 0); cyc(C_LW, rnd(), 1); cyc(C_LW, rnd(), 2);
        cyc(C_LW, 1'b1, 3); cyc(C_LW, rnd(), 4);
        // SW with three wait cycles in MEMWR
        cyc(C_SW, 1'b1, 0); cyc(C_SW, rnd(), 1); cyc(C_SW, rnd(), 2);
        cyc(C_SW, 1'b0, 5); cyc(C_SW, 1'b0, 5); cyc(C_SW, 1'b0, 5); cyc(C_SW, 1'b1, 5);
        // BEQ then J
        cyc(C_BEQ, 1'b1, 0); cyc(C_BEQ, rnd(), 1); cyc(C_BEQ, rnd(), 8);
        cyc(C_J, 1'b1, 0); cyc(C_J, rnd(), 1); cyc(C_J, rnd(), 9);
        // FETCH stall of two cycles, R-type
        cyc(C_RTYPE, 1'b0, 0); cyc(C_RTYPE, 1'b0, 0); cyc(C_RTYPE, 1'b1, 0);
        cyc(C_RTYPE, rnd(), 1); cyc(C_RTYPE, rnd(), 6); cyc(C_RTYPE, rnd(), 7);
        // ADDI
        cyc(C_ADDI, 1'b1, 0); cyc(C_ADDI, rnd(), 1); cyc(C_ADDI, rnd(), 10); cyc(C_ADDI, rnd(), 11);
        // LW with one MEMRD wait
        cyc(C_LW, 1'b1, 0); cyc(C_LW, rnd(), 1); cyc(C_LW, rnd(), 2);
        cyc(C_LW, 1'b0, 3); cyc(C_LW, 1'b1, 3); cyc(C_LW, rnd(), 4);
        // Illegal opcode, then an R-type with the flag still set
        cyc(C_BAD, 1'b1, 0); cyc(C_BAD, rnd(), 1);
        exp_ill = 1'b1;
        cyc(C_RTYPE, 1'b1, 0); cyc(C_RTYPE, rnd(), 1); cyc(C_RTYPE, rnd(), 6); cyc(C_RTYPE, rnd(), 7);

        // SW stalled in MEMWR, then asynchronous reset mid-instruction
        cyc(C_SW, 1'b1, 0); cyc(C_SW, rnd(), 1); cyc(C_SW, rnd(), 2); cyc(C_SW, 1'b0, 5);
        chk("pre_rst_state", 32'(state_out), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_memwrite", 32'(MemWrite), 32'd0);
        chk("arst_memread", 32'(MemRead), 32'd1);
        chk("arst_illegal", 32'(illegal_op), 32'd0);
        chk("arst_pcwrite_lo", 32'(PCwrite), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("arst_pcwrite_hi", 32'(PCwrite), 32'd1);
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_ill = 1'b0;
        @(posedge clk);
        #1;

        // J after reset returns to normal sequencing
        cyc(C_J, 1'b1, 0); cyc(C_J, rnd(), 1); cyc(C_J, rnd(), 9);
        cyc(C_RTYPE, 1'b0, 0);

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
